// File: rtl/dzcpu_uop_sequencer_pkg.sv
// Shared micro-op definitions for the dzcpu sequencer: flow-control codes,
// the CB-jump body opcode and the sequencer state encodings.
package dzcpu_uop_sequencer_pkg;

    localparam int FLOW_W = 4;

    localparam logic [FLOW_W-1:0] FLOW_OP           = 4'd0;
    localparam logic [FLOW_W-1:0] FLOW_INC          = 4'd1;
    localparam logic [FLOW_W-1:0] FLOW_EOF          = 4'd2;
    localparam logic [FLOW_W-1:0] FLOW_INC_EOF      = 4'd3;
    localparam logic [FLOW_W-1:0] FLOW_EOF_FU       = 4'd4;
    localparam logic [FLOW_W-1:0] FLOW_INC_EOF_FU   = 4'd5;
    localparam logic [FLOW_W-1:0] FLOW_INC_EOF_Z    = 4'd6;
    localparam logic [FLOW_W-1:0] FLOW_INC_EOF_NZ   = 4'd7;
    localparam logic [FLOW_W-1:0] FLOW_UPDATE_FLAGS = 4'd8;
    localparam logic [FLOW_W-1:0] FLOW_NOP          = 4'd9;

    // Op subfield occupies the top five bits of the 9-bit uop body.
    localparam int            OP_LSB  = 4;
    localparam int            OP_W    = 5;
    localparam logic [OP_W-1:0] UOP_JCB = 5'h1F;

    typedef enum logic [1:0] {
        S_WAIT_OP = 2'd0,
        S_EXEC    = 2'd1,
        S_WAIT_CB = 2'd2
    } seq_state_e;

endpackage

// File: rtl/dzcpu_uop_flow_decode.sv
// Combinational decode of a uop flow-control field into sequencing strobes.
module dzcpu_uop_flow_decode
    import dzcpu_uop_sequencer_pkg::*;
(
    input  logic [FLOW_W-1:0] iFlow,
    input  logic              iZeroFlag,
    output logic              oAdvance,
    output logic              oEof,
    output logic              oIncPc,
    output logic              oFlagsUpdate
);

    always_comb begin
        oAdvance     = 1'b0;
        oEof         = 1'b0;
        oIncPc       = 1'b0;
        oFlagsUpdate = 1'b0;
        case (iFlow)
            FLOW_OP, FLOW_NOP: oAdvance = 1'b1;
            FLOW_INC: begin
                oIncPc   = 1'b1;
                oAdvance = 1'b1;
            end
            FLOW_UPDATE_FLAGS: begin
                oFlagsUpdate = 1'b1;
                oAdvance     = 1'b1;
            end
            FLOW_EOF: oEof = 1'b1;
            FLOW_INC_EOF: begin
                oIncPc = 1'b1;
                oEof   = 1'b1;
            end
            FLOW_EOF_FU: begin
                oEof         = 1'b1;
                oFlagsUpdate = 1'b1;
            end
            FLOW_INC_EOF_FU: begin
                oIncPc       = 1'b1;
                oEof         = 1'b1;
                oFlagsUpdate = 1'b1;
            end
            FLOW_INC_EOF_Z: begin
                oIncPc   = 1'b1;
                oEof     = iZeroFlag;
                oAdvance = !iZeroFlag;
            end
            FLOW_INC_EOF_NZ: begin
                oIncPc   = 1'b1;
                oEof     = !iZeroFlag;
                oAdvance = iZeroFlag;
            end
            // Reserved codes end the flow so a corrupt ROM word cannot run away.
            default: oEof = 1'b1;
        endcase
    end

endmodule

// File: rtl/dzcpu_uop_sequencer.sv
// Microcode sequencer: owns the uPC, fetches uops from the ROM, resolves flow
// control (EOF, conditional EOF on Z, CB redirect, interrupt entry).
// Handshake: a uop body is consumed by the datapath in every cycle where
// oUopValid=1; iStall=1 holds the uop and suppresses every strobe.
module dzcpu_uop_sequencer
    import dzcpu_uop_sequencer_pkg::*;
#(
    parameter int         UOP_W        = 13,
    parameter int         FLOW_W       = 4,
    parameter logic [7:0] INT_FLOW_IDX = 8'd172,
    parameter logic [7:0] CB_PREFIX    = 8'hCB
) (
    input  logic                    iClock,
    input  logic                    iReset,
    input  logic [7:0]              iMop,
    input  logic                    iMopValid,
    input  logic [7:0]              iLutIdx,
    input  logic [7:0]              iCbLutIdx,
    output logic [7:0]              oUopAddr,
    input  logic [UOP_W-1:0]        iUop,
    input  logic                    iStall,
    input  logic                    iZeroFlag,
    input  logic                    iIntReq,
    output logic                    oUopValid,
    output logic [UOP_W-FLOW_W-1:0] oUopBody,
    output logic                    oIncPc,
    output logic                    oFlagsUpdate,
    output logic                    oEof,
    output logic                    oIntAck,
    output logic                    oIllegal,
    output logic                    oBusy,
    output logic [1:0]              oDbgState
);

    seq_state_e state_q, state_d;
    logic [7:0] upc_q, upc_d;

    logic dec_advance, dec_eof, dec_inc_pc, dec_flags_update;
    logic is_jcb;
    logic uop_valid, inc_pc, flags_update, eof, int_ack, illegal;

    // CB redirection is driven by the JCB uop, so the raw opcode is not decoded here.
    logic unused_mop;
    assign unused_mop = (iMop == CB_PREFIX);

    assign oUopBody = iUop[UOP_W-FLOW_W-1:0];
    assign is_jcb   = (oUopBody[OP_LSB +: OP_W] == UOP_JCB);

    dzcpu_uop_flow_decode u_flow_decode (
        .iFlow        (iUop[UOP_W-1 -: FLOW_W]),
        .iZeroFlag    (iZeroFlag),
        .oAdvance     (dec_advance),
        .oEof         (dec_eof),
        .oIncPc       (dec_inc_pc),
        .oFlagsUpdate (dec_flags_update)
    );

    always_comb begin
        state_d      = state_q;
        upc_d        = upc_q;
        uop_valid    = 1'b0;
        inc_pc       = 1'b0;
        flags_update = 1'b0;
        eof          = 1'b0;
        int_ack      = 1'b0;
        illegal      = 1'b0;
        case (state_q)
            S_WAIT_OP: begin
                if (iIntReq) begin
                    upc_d   = INT_FLOW_IDX;
                    int_ack = 1'b1;
                    state_d = S_EXEC;
                end else if (iMopValid) begin
                    upc_d   = iLutIdx;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!iStall) begin
                    uop_valid    = 1'b1;
                    inc_pc       = dec_inc_pc;
                    flags_update = dec_flags_update;
                    // JCB parks the uPC and waits for the CB opcode byte.
                    if (is_jcb) begin
                        state_d = S_WAIT_CB;
                    end else if (dec_eof) begin
                        eof     = 1'b1;
                        state_d = S_WAIT_OP;
                    end else if (dec_advance) begin
                        upc_d = upc_q + 8'd1;
                    end
                end
            end
            S_WAIT_CB: begin
                if (iMopValid) begin
                    if (iCbLutIdx != 8'd0) begin
                        upc_d   = iCbLutIdx;
                        state_d = S_EXEC;
                    end else begin
                        illegal = 1'b1;
                        state_d = S_WAIT_OP;
                    end
                end
            end
            default: state_d = S_WAIT_OP;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= S_WAIT_OP;
            upc_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
        end
    end

    // Reset gates every strobe so an abandoned flow emits nothing in the reset cycle.
    assign oUopAddr     = upc_q;
    assign oUopValid    = uop_valid & ~iReset;
    assign oIncPc       = inc_pc & ~iReset;
    assign oFlagsUpdate = flags_update & ~iReset;
    assign oEof         = eof & ~iReset;
    assign oIntAck      = int_ack & ~iReset;
    assign oIllegal     = illegal & ~iReset;
    assign oBusy        = (state_q == S_EXEC) & ~iReset;
    assign oDbgState    = state_q;

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// Directed bench for dzcpu_uop_sequencer: a bench-side ROM image plus a
// table of per-cycle inputs and hand-computed expected outputs.
module tb_dzcpu_uop_sequencer;
    import dzcpu_uop_sequencer_pkg::*;

    localparam logic [1:0] SW = S_WAIT_OP;
    localparam logic [1:0] SE = S_EXEC;
    localparam logic [1:0] SC = S_WAIT_CB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mop = 8'h00;
    logic        mop_valid = 1'b0;
    logic [7:0]  lut_idx = 8'd0;
    logic [7:0]  cb_idx = 8'd0;
    logic [7:0]  uop_addr;
    logic [12:0] uop;
    logic        stall = 1'b0;
    logic        zero = 1'b0;
    logic        int_req = 1'b0;
    logic        uop_valid, inc_pc, flags_update, eof, int_ack, illegal, busy;
    logic [8:0]  uop_body;
    logic [1:0]  dbg_state;

    logic [12:0] rom [0:255];
    assign uop = rom[uop_addr];

    always #5 clk = ~clk;

    dzcpu_uop_sequencer dut (
        .iClock(clk), .iReset(rst), .iMop(mop), .iMopValid(mop_valid),
        .iLutIdx(lut_idx), .iCbLutIdx(cb_idx), .oUopAddr(uop_addr), .iUop(uop),
        .iStall(stall), .iZeroFlag(zero), .iIntReq(int_req),
        .oUopValid(uop_valid), .oUopBody(uop_body), .oIncPc(inc_pc),
        .oFlagsUpdate(flags_update), .oEof(eof), .oIntAck(int_ack),
        .oIllegal(illegal), .oBusy(busy), .oDbgState(dbg_state)
    );

    typedef struct {
        logic       rst, mv, stall, z, irq;
        logic [7:0] lut, cb;
        logic [7:0] addr;
        logic       val, inc, fu, eof, ack, ill;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic r, logic mv, logic [7:0] lut, logic [7:0] cb,
                                logic s, logic z, logic irq, logic [7:0] addr,
                                logic val, logic inc, logic fu, logic e,
                                logic ack, logic ill, logic [1:0] st);
        vec_t t;
        t.rst = r; t.mv = mv; t.lut = lut; t.cb = cb; t.stall = s; t.z = z; t.irq = irq;
        t.addr = addr; t.val = val; t.inc = inc; t.fu = fu; t.eof = e;
        t.ack = ack; t.ill = ill; t.st = st;
        return t;
    endfunction

    // Table entry with reset and stall low.
    task automatic v(logic mv, logic [7:0] lut, logic [7:0] cb, logic z, logic irq,
                     logic [7:0] addr, logic val, logic inc, logic fu, logic e,
                     logic ack, logic ill, logic [1:0] st);
        vecs.push_back(mk(1'b0, mv, lut, cb, 1'b0, z, irq, addr, val, inc, fu, e, ack, ill, st));
    endtask

    function automatic void set_rom(int idx, logic [3:0] flow);
        rom[idx] = {flow, 5'd1, 4'(idx)};
    endfunction

    task automatic step(input vec_t t, input string name);
        logic [16:0] act, exp;
        logic        exp_busy;
        @(posedge clk);
        #1;
        rst = t.rst; mop_valid = t.mv; lut_idx = t.lut; cb_idx = t.cb;
        stall = t.stall; zero = t.z; int_req = t.irq;
        mop = t.mv ? 8'hCB : 8'h00;
        @(negedge clk);
        exp_busy = (t.st == SE) && !t.rst;
        act = {uop_addr, uop_valid, inc_pc, flags_update, eof, int_ack, illegal, busy, dbg_state};
        exp = {t.addr, t.val, t.inc, t.fu, t.eof, t.ack, t.ill, exp_busy, t.st};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: {addr,val,inc,fu,eof,ack,ill,busy,st} got %h/%b required %h/%b",
                     name, act[16:9], act[8:0], exp[16:9], exp[8:0]);
        end
        if (t.val) begin
            n_tests++;
            if (uop_body !== rom[t.addr][8:0]) begin
                n_fail++;
                $display("FAIL %s body: got %h required %h", name, uop_body, rom[t.addr][8:0]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {FLOW_EOF, 9'h000};
        set_rom(23, FLOW_INC); set_rom(24, FLOW_INC); set_rom(25, FLOW_EOF);
        set_rom(17, FLOW_OP); set_rom(18, FLOW_OP); set_rom(19, FLOW_INC_EOF_Z);
        set_rom(20, FLOW_OP); set_rom(21, FLOW_INC); set_rom(22, FLOW_EOF);
        set_rom(13, FLOW_OP); set_rom(14, FLOW_OP);
        rom[15] = {FLOW_INC, UOP_JCB, 4'd0};
        set_rom(16, FLOW_EOF_FU);
        set_rom(172, FLOW_OP); set_rom(173, FLOW_EOF);
        set_rom(255, FLOW_OP); set_rom(0, FLOW_EOF);
        set_rom(60, 4'd12);
        set_rom(70, FLOW_UPDATE_FLAGS); set_rom(71, FLOW_NOP); set_rom(72, FLOW_INC_EOF_FU);
        set_rom(80, FLOW_INC_EOF_NZ); set_rom(81, FLOW_EOF);
        set_rom(61, FLOW_OP); set_rom(62, FLOW_INC_EOF);
        set_rom(40, FLOW_OP); set_rom(41, FLOW_INC); set_rom(42, FLOW_EOF);
        set_rom(50, FLOW_OP); set_rom(51, FLOW_OP); set_rom(52, FLOW_OP); set_rom(53, FLOW_EOF);

        //  mv lut  cb  z irq  addr val inc fu eof ack ill st
        v(0,   0,  0, 0, 0,    0, 0, 0, 0, 0, 0, 0, SW);
        // INC,INC,EOF flow at 23
        v(1,  23,  0, 0, 0,    0, 0, 0, 0, 0, 0, 0, SW);
        v(0,   0,  0, 0, 0,   23, 1, 1, 0, 0, 0, 0, SE);
        v(0,   0,  0, 0, 0,   24, 1, 1, 0, 0, 0, 0, SE);
        v(0,   0,  0, 0, 0,   25, 1, 0, 0, 1, 0, 0, SE);
        v(0,   0,  0, 0, 0,   25, 0, 0, 0, 0, 0, 0, SW);
        // JRNZ-style flow, Z=1 ends at 19
        v(1,  17,  0, 1, 0,   25, 0, 0, 0, 0, 0, 0, SW);
        v(0,   0,  0, 1, 0,   17, 1, 0, 0, 0, 0, 0, SE);
        v(0,   0,  0, 1, 0,   18, 1, 0, 0, 0, 0, 0, SE);
        v(0,   0,  0, 1, 0,   19, 1, 1, 0, 1, 0, 0, SE);
        v(0,   0,  0, 1, 0,   19, 0, 0, 0, 0, 0, 0, SW);
        // Z=0 continues to 22
        v(1,  17,  0, 0, 0,   19, 0, 0, 0, 0, 0, 0, SW);
        v(0,   0,  0, 0, 0,   17, 1, 0, 0, 0, 0, 0, SE);
        v(0,   0,  0, 0, 0,   18, 1, 0, 0, 0, 0, 0, SE);
        v(0,   0,  0, 0, 0,   19, 1, 1, 0, 0, 0, 0, SE);
        v(0,   0,  0, 0, 0,   20, 1, 0, 0, 0, 0, 0, SE);
        v(0,   0,  0, 0, 0,   21, 1, 1, 0, 0, 0, 0, SE);
        v(0,   0,  0, 0, 0,   22, 1, 0, 0, 1, 0, 0, SE);
        v(0,   0,  0, 0, 0,   22, 0, 0, 0, 0, 0, 0, SW);
        // CB prefix: JCB at 15, interrupt ignored in WAIT_CB, CB flow at 16
        v(1,  13,  0, 0, 0,   22, 0, 0, 0, 0, 0, 0, SW);
        v(0,   0,  0, 0, 0,   13, 1, 0, 0, 0, 0, 0, SE);
        v(0,   0,  0, 0, 0,   14, 1, 0, 0, 0, 0, 0, SE);
        v(0,   0,  0, 0, 0,   15, 1, 1, 0, 0, 0, 0, SE);
        v(0,   0,  0, 0, 1,   15, 0, 0, 0, 0, 0, 0, SC);
        v(1,   0, 16, 0, 0,   15, 0, 0, 0, 0, 0, 0, SC);
        v(0,   0,  0, 0, 0,   16, 1, 0, 1, 1, 0, 0, SE);
        v(0,   0,  0, 0, 0,   16, 0, 0, 0, 0, 0, 0, SW);
        // Unmapped CB opcode
        v(1,  13,  0, 0, 0,   16, 0, 0, 0, 0, 0, 0, SW);
        v(0,   0,  0, 0, 0,   13, 1, 0, 0, 0, 0, 0, SE);
        v(0,   0,  0, 0, 0,   14, 1, 0, 0, 0, 0, 0, SE);
        v(0,   0,  0, 0, 0,   15, 1, 1, 0, 0, 0, 0, SE);
        v(1,   0,  0, 0, 0,   15, 0, 0, 0, 0, 0, 1, SC);
        v(0,   0,  0, 0, 0,   15, 0, 0, 0, 0, 0, 0, SW);
        // Interrupt beats opcode
        v(1,  23,  0, 0, 1,   15, 0, 0, 0, 0, 1, 0, SW);
        v(0,   0,  0, 0, 0,  172, 1, 0, 0, 0, 0, 0, SE);
        v(0,   0,  0, 0, 0,  173, 1, 0, 0, 1, 0, 0, SE);
        v(0,   0,  0, 0, 0,  173, 0, 0, 0, 0, 0, 0, SW);
        // uPC wrap FF -> 00
        v(1, 255,  0, 0, 0,  173, 0, 0, 0, 0, 0, 0, SW);
        v(0,   0,  0, 0, 0,  255, 1, 0, 0, 0, 0, 0, SE);
        v(0,   0,  0, 0, 0,    0, 1, 0, 0, 1, 0, 0, SE);
        v(0,   0,  0, 0, 0,    0, 0, 0, 0, 0, 0, 0, SW);
        // Reserved flow code acts as EOF
        v(1,  60,  0, 0, 0,    0, 0, 0, 0, 0, 0, 0, SW);
        v(0,   0,  0, 0, 0,   60, 1, 0, 0, 1, 0, 0, SE);
        // UPDATE_FLAGS, NOP, INC_EOF_FU
        v(1,  70,  0, 0, 0,   60, 0, 0, 0, 0, 0, 0, SW);
        v(0,   0,  0, 0, 0,   70, 1, 0, 1, 0, 0, 0, SE);
        v(0,   0,  0, 0, 0,   71, 1, 0, 0, 0, 0, 0, SE);
        v(0,   0,  0, 0, 0,   72, 1, 1, 1, 1, 0, 0, SE);
        // INC_EOF_NZ both ways
        v(1,  80,  0, 1, 0,   72, 0, 0, 0, 0, 0, 0, SW);
        v(0,   0,  0, 1, 0,   80, 1, 1, 0, 0, 0, 0, SE);
        v(0,   0,  0, 1, 0,   81, 1, 0, 0, 1, 0, 0, SE);
        v(1,  80,  0, 0, 0,   81, 0, 0, 0, 0, 0, 0, SW);
        v(0,   0,  0, 0, 0,   80, 1, 1, 0, 1, 0, 0, SE);
        // INC_EOF
        v(1,  61,  0, 0, 0,   80, 0, 0, 0, 0, 0, 0, SW);
        v(0,   0,  0, 0, 0,   61, 1, 0, 0, 0, 0, 0, SE);
        v(0,   0,  0, 0, 0,   62, 1, 1, 0, 1, 0, 0, SE);
        v(0,   0,  0, 0, 0,   62, 0, 0, 0, 0, 0, 0, SW);

        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, SW), "reset0");
        step(mk(1, 1, 9, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, SW), "reset1");
        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

        // Stall held three cycles on an INC uop, then once on the EOF uop
        step(mk(0, 1, 40, 0, 0, 0, 0, 62, 0, 0, 0, 0, 0, 0, SW), "stall_start");
        step(mk(0, 0, 0, 0, 0, 0, 0, 40, 1, 0, 0, 0, 0, 0, SE), "stall_op");
        for (int i = 0; i < 3; i++)
            step(mk(0, 0, 0, 0, 1, 0, 0, 41, 0, 0, 0, 0, 0, 0, SE), $sformatf("stall_hold%0d", i));
        step(mk(0, 0, 0, 0, 0, 0, 0, 41, 1, 1, 0, 0, 0, 0, SE), "stall_release");
        step(mk(0, 0, 0, 0, 1, 0, 0, 42, 0, 0, 0, 0, 0, 0, SE), "stall_eof_hold");
        step(mk(0, 0, 0, 0, 0, 0, 0, 42, 1, 0, 0, 1, 0, 0, SE), "stall_eof");
        step(mk(0, 0, 0, 0, 0, 0, 0, 42, 0, 0, 0, 0, 0, 0, SW), "stall_idle");

        // Reset asserted mid-flow at uPC 52
        step(mk(0, 1, 50, 0, 0, 0, 0, 42, 0, 0, 0, 0, 0, 0, SW), "rst_start");
        step(mk(0, 0, 0, 0, 0, 0, 0, 50, 1, 0, 0, 0, 0, 0, SE), "rst_50");
        step(mk(0, 0, 0, 0, 0, 0, 0, 51, 1, 0, 0, 0, 0, 0, SE), "rst_51");
        step(mk(1, 0, 0, 0, 0, 0, 0, 52, 0, 0, 0, 0, 0, 0, SE), "rst_cycle");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, SW), "rst_after");
        step(mk(0, 1, 23, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, SW), "rst_refetch");
        step(mk(0, 0, 0, 0, 0, 0, 0, 23, 1, 1, 0, 0, 0, 0, SE), "rst_refetch_exec");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
